// File: rtl/game_seq_ctrl.sv
// Round sequencer for a timed target game: start/level handling, countdown, scoring, spawn requests.
// Latency: start/hit/tick take effect at the next clk edge; spawn_req follows a hit by one cycle.
// No backpressure: all pulses are fire-and-forget. Optional high score via GAME_SEQ_HISCORE_EN.
module game_seq_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int SCROLL_DIV = 15000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_n,
  input  logic [2:0]  level_n,
  input  logic        hit,
  output logic [1:0]  phase,
  output logic [6:0]  countdown,
  output logic [10:0] score,
  output logic [9:0]  led,
  output logic        scroll_step,
  output logic        spawn_req,
  output logic [1:0]  spawn_lane,
`ifdef GAME_SEQ_HISCORE_EN
  output logic [10:0] hiscore,
  output logic        new_record,
`endif
  output logic        round_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [10:0]   SCORE_MAX   = 11'd2047;

  state_t          state;
  state_t          state_nxt;
  logic            start_q;
  logic            start_evt;
  logic [6:0]      sel_time;
  logic [6:0]      sel_nxt;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            final_tick;
  logic            hit_ok;
  logic [10:0]     score_nxt;
  logic [SW-1:0]   scr_cnt;
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  logic [1:0]      lane_mod;

  assign phase = state;

  // Falling edge of the start button, seen against its one-cycle-old copy.
  always_comb begin
    start_evt = start_q & ~start_n;
  end

  // Level decode: lowest asserted bit wins; nothing pressed keeps the current choice.
  always_comb begin
    sel_nxt = sel_time;
    if (!level_n[0]) begin
      sel_nxt = 7'd30;
    end else if (!level_n[1]) begin
      sel_nxt = 7'd60;
    end else if (!level_n[2]) begin
      sel_nxt = 7'd90;
    end
  end

  // Second tick and end-of-round detection; a hit only counts while playing.
  always_comb begin
    tick       = (state == PLAY) && (tick_cnt == TICK_LAST);
    final_tick = tick && (countdown == 7'd1);
    hit_ok     = hit && (state == PLAY);
    score_nxt  = score;
    if (hit_ok && (score != SCORE_MAX)) begin
      score_nxt = score + 11'd1;
    end
  end

  // Next-state logic: start only acts outside PLAY, the last tick ends the round.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_evt) state_nxt = PLAY;
      PLAY: if (final_tick) state_nxt = OVER;
      OVER: if (start_evt) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Single registration of the start button for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start_n;
    end
  end

  // Selected round length; frozen while a round is in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_time <= 7'd30;
    end else if (state != PLAY) begin
      sel_time <= sel_nxt;
    end
  end

  // Countdown tracks the selection between rounds and counts down once per tick in PLAY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      countdown <= 7'd30;
    end else if (state != PLAY) begin
      countdown <= sel_nxt;
    end else if (tick) begin
      countdown <= countdown - 7'd1;
    end
  end

  // Second prescaler: idle at zero outside PLAY so every round starts on a fresh second.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if ((state != PLAY) || (tick_cnt == TICK_LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Score: cleared by a start event, held in OVER, saturating increment on hits in PLAY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      score <= '0;
    end else if ((state != PLAY) && start_evt) begin
      score <= '0;
    end else begin
      score <= score_nxt;
    end
  end

  // Milestone bar: one LED per 20 hits.
  always_comb begin
    led = '0;
    for (int k = 0; k < 10; k++) begin
      led[k] = (score >= 11'(20 * (k + 1)));
    end
  end

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR feeding the lane choice.
  always_comb begin
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    lane_mod = 2'(lfsr % 8'd3);
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Spawn request one cycle after a counted hit, lane captured from the hit cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      spawn_req  <= 1'b0;
      spawn_lane <= 2'd0;
    end else begin
      spawn_req <= hit_ok;
      if (hit_ok) begin
        spawn_lane <= lane_mod;
      end
    end
  end

  // End-of-round pulse coincides with the first OVER cycle; reset aborts silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      round_done <= 1'b0;
    end else begin
      round_done <= final_tick;
    end
  end

  // Banner scroll prescaler: runs only between rounds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scr_cnt <= '0;
    end else if ((state == PLAY) || (scr_cnt == SCROLL_LAST)) begin
      scr_cnt <= '0;
    end else begin
      scr_cnt <= scr_cnt + SW'(1);
    end
  end

  // Scroll pulse on prescaler wrap, suppressed during play.
  always_comb begin
    scroll_step = (state != PLAY) && (scr_cnt == SCROLL_LAST);
  end

`ifdef GAME_SEQ_HISCORE_EN
  // High score updates with the final score (including a last-tick hit); only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hiscore    <= '0;
      new_record <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (final_tick && (score_nxt > hiscore)) begin
        hiscore    <= score_nxt;
        new_record <= 1'b1;
      end
    end
  end
`endif

endmodule
